// File: rtl/wf_mode_sequencer_pkg.sv
// Shared types and constants for the mode sequencer.
// Holds the FSM state enum, mode constants and the mode step helper.
package wf_pkg;

    localparam int MODE_W = 4;

    typedef enum logic [1:0] {
        BOOT,
        START,
        RUN,
        SHOW
    } wf_state_e;

    localparam logic [MODE_W-1:0] MODE_GOLDEN    = 4'd0;
    localparam logic [MODE_W-1:0] MODE_QSIM      = 4'd14;
    localparam logic [MODE_W-1:0] MODE_ROUNDTRIP = 4'd15;

    localparam logic [3:0] ERR_LED_PFX = 4'hE;

    function automatic logic [MODE_W-1:0] mode_step(
        input logic [MODE_W-1:0] m,
        input int unsigned       n
    );
        if ({28'd0, m} >= n - 1) return '0;
        return m + 1'b1;
    endfunction

endpackage

// File: rtl/wf_mode_sequencer_if.sv
// Start/done handshake between the sequencer and the compute core.
// The sequencer is master; the core is slave.
interface wf_core_if;
    import wf_pkg::*;

    logic              core_start;
    logic [MODE_W-1:0] core_mode;
    logic              core_done;
    logic [7:0]        core_result;

    modport master (
        output core_start, core_mode,
        input  core_done, core_result
    );

    modport slave (
        input  core_start, core_mode,
        output core_done, core_result
    );

endinterface

// File: rtl/wf_btn_debounce.sv
// Two-flop synchronizer plus counter debounce for an active-low button.
// Emits the stable level and a one-cycle pulse on each accepted press.
module wf_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_n_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample matching the stable level restarts the count.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = s2_q;
                press_d = !s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/wf_mode_sequencer.sv
// Button-driven mode stepper that starts the core and shows its result.
// Waits for core done or a timeout and latches the outcome onto the LEDs.
module wf_mode_sequencer
    import wf_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 20,
    parameter int unsigned AUTOSTART_CYCLES = 20,
    parameter int unsigned TIMEOUT_CYCLES   = 1024,
    parameter int unsigned DEFAULT_MODE     = 14,
    parameter int unsigned NUM_MODES        = 16
) (
    input  logic          WF_CLK,
    input  logic          rst_n,
    input  logic          btn_n,
    wf_core_if.master     core,
    output logic [7:0]    led,
    output logic          err,
    output logic          busy
);

    localparam int BW = $clog2(AUTOSTART_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    wf_state_e         state_q, state_d;
    logic [BW-1:0]     boot_q, boot_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              pend_q, pend_d;
    logic [7:0]        led_q, led_d;
    logic              err_q, err_d;
    logic              press;
    logic              level_unused;

    wf_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (WF_CLK),
        .rst_n  (rst_n),
        .btn_n_i(btn_n),
        .level_o(level_unused),
        .press_o(press)
    );

    always_ff @(posedge WF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            boot_q  <= '0;
            tmo_q   <= '0;
            mode_q  <= MODE_W'(DEFAULT_MODE);
            pend_q  <= 1'b0;
            led_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= boot_d;
            tmo_q   <= tmo_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        boot_d  = boot_q;
        tmo_d   = tmo_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        led_d   = led_q;
        err_d   = err_q;
        unique case (state_q)
            BOOT: begin
                if (press) pend_d = 1'b1;
                if (boot_q == BW'(AUTOSTART_CYCLES - 1)) state_d = START;
                else boot_d = boot_q + 1'b1;
            end
            START: begin
                if (press) pend_d = 1'b1;
                tmo_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (press) pend_d = 1'b1;
                if (core.core_done) begin
                    led_d = core.core_result;
                    err_d = 1'b0;
                    // A press landing with done still counts as pending.
                    if (pend_q || press) begin
                        mode_d  = mode_step(mode_q, NUM_MODES);
                        pend_d  = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = SHOW;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    led_d   = {ERR_LED_PFX, mode_q};
                    err_d   = 1'b1;
                    state_d = SHOW;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SHOW: begin
                if (press || pend_q) begin
                    mode_d  = mode_step(mode_q, NUM_MODES);
                    pend_d  = 1'b0;
                    state_d = START;
                end
            end
        endcase
    end

    assign core.core_start = (state_q == START);
    assign core.core_mode  = mode_q;
    assign busy            = (state_q == START) || (state_q == RUN);
    assign led             = led_q;
    assign err             = err_q;

endmodule

// File: tb/tb_wf_mode_sequencer.sv
// Directed bench for the mode sequencer.
// Each task drives one scenario and checks hand-computed values.
module tb_wf_mode_sequencer;
    import wf_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic [7:0] led;
    logic       err;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    wf_core_if cif ();

    wf_mode_sequencer dut (
        .WF_CLK(clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .core  (cif.master),
        .led   (led),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic pulse_done(input logic [7:0] r);
        @(negedge clk);
        cif.core_result = r;
        cif.core_done   = 1'b1;
        @(negedge clk);
        cif.core_done   = 1'b0;
    endtask

    task automatic press_btn(input int lo, input int hi,
                             output int starts);
        starts = 0;
        btn_n  = 1'b0;
        repeat (lo) begin
            @(negedge clk);
            if (cif.core_start === 1'b1) starts++;
        end
        btn_n = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            if (cif.core_start === 1'b1) starts++;
        end
    endtask

    task automatic wait_start(input int lim, output int n);
        n = 0;
        while (cif.core_start !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n           = 1'b0;
        btn_n           = 1'b1;
        cif.core_done   = 1'b0;
        cif.core_result = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cif.core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_start: got %b expected 0", cif.core_start);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd14) begin
            n_bad++;
            $display("FAIL rst_mode: got %0d expected 14", cif.core_mode);
        end
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_led: got %h expected 00", led);
        end
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_err_busy: got %b%b expected 00", err, busy);
        end
    endtask

    task automatic test_autostart;
        rst_n = 1'b1;
        repeat (19) @(negedge clk);
        n_cmp++;
        if (cif.core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_early: got %b expected 0", cif.core_start);
        end
        @(negedge clk);
        n_cmp++;
        if (cif.core_start !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL auto_start: got %b%b expected 11",
                     cif.core_start, busy);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd14) begin
            n_bad++;
            $display("FAIL auto_mode: got %0d expected 14", cif.core_mode);
        end
        @(negedge clk);
        n_cmp++;
        if (cif.core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_pulse: got %b expected 0", cif.core_start);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (led !== 8'h00) begin
            n_bad++;
            $display("FAIL auto_led_hold: got %h expected 00", led);
        end
        pulse_done(8'hA5);
        n_cmp++;
        if (led !== 8'hA5 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_led: got %h/%b expected a5/0", led, err);
        end
        n_cmp++;
        if (busy !== 1'b0 || cif.core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_show: got %b%b expected 00",
                     busy, cif.core_start);
        end
    endtask

    task automatic test_press;
        int s;
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 1) begin
            n_bad++;
            $display("FAIL press_starts: got %0d expected 1", s);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd15 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL press_mode: got %0d/%b expected 15/1",
                     cif.core_mode, busy);
        end
        pulse_done(8'h5A);
        n_cmp++;
        if (led !== 8'h5A) begin
            n_bad++;
            $display("FAIL press_led: got %h expected 5a", led);
        end
    endtask

    task automatic test_wrap;
        int s;
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 1 || cif.core_mode !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap_mode: got %0d/%0d expected 1/0",
                     s, cif.core_mode);
        end
        pulse_done(8'h3C);
        n_cmp++;
        if (led !== 8'h3C || err !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_led: got %h/%b expected 3c/0", led, err);
        end
    endtask

    task automatic test_glitch;
        int s;
        press_btn(10, 40, s);
        n_cmp++;
        if (s != 0) begin
            n_bad++;
            $display("FAIL glitch_starts: got %0d expected 0", s);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd0 || led !== 8'h3C || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_state: got %0d/%h/%b expected 0/3c/0",
                     cif.core_mode, led, busy);
        end
    endtask

    task automatic test_back_to_back;
        int s;
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 1 || cif.core_mode !== 4'd1) begin
            n_bad++;
            $display("FAIL b2b_first: got %0d/%0d expected 1/1",
                     s, cif.core_mode);
        end
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 0) begin
            n_bad++;
            $display("FAIL b2b_press1: got %0d expected 0", s);
        end
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 0 || busy !== 1'b1 || cif.core_mode !== 4'd1) begin
            n_bad++;
            $display("FAIL b2b_press2: got %0d/%b/%0d expected 0/1/1",
                     s, busy, cif.core_mode);
        end
        pulse_done(8'h77);
        n_cmp++;
        if (led !== 8'h77 || cif.core_start !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_restart: got %h/%b expected 77/1",
                     led, cif.core_start);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd2) begin
            n_bad++;
            $display("FAIL b2b_mode: got %0d expected 2", cif.core_mode);
        end
        pulse_done(8'h88);
        n_cmp++;
        if (led !== 8'h88 || busy !== 1'b0 || cif.core_mode !== 4'd2) begin
            n_bad++;
            $display("FAIL b2b_single: got %h/%b/%0d expected 88/0/2",
                     led, busy, cif.core_mode);
        end
    endtask

    task automatic test_timeout;
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(40, n);
        n_cmp++;
        if (cif.core_start !== 1'b1 || n != 20) begin
            n_bad++;
            $display("FAIL tmo_autostart: got %b/%0d expected 1/20",
                     cif.core_start, n);
        end
        repeat (1024) @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_early: got %b%b expected 01", err, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || led !== 8'hEE || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_fire: got %b/%h/%b expected 1/ee/0",
                     err, led, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int s;
        press_btn(25, 30, s);
        n_cmp++;
        if (s != 1 || cif.core_mode !== 4'd15 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_pre: got %0d/%0d/%b expected 1/15/1",
                     s, cif.core_mode, busy);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cif.core_start !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_ctl: got %b%b%b expected 000",
                     cif.core_start, busy, err);
        end
        n_cmp++;
        if (cif.core_mode !== 4'd14 || led !== 8'h00) begin
            n_bad++;
            $display("FAIL midrun_out: got %0d/%h expected 14/00",
                     cif.core_mode, led);
        end
    endtask

    initial begin
        test_reset();
        test_autostart();
        test_press();
        test_wrap();
        test_glitch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
